// File: rtl/crash_sequencer.sv
// Game-over sequencer: blinks the crash overlay, holds it steady, then waits for
// a fresh restart press and issues a one-cycle game reset aligned to a frame.
module crash_sequencer #(
  parameter int BLINK_FRAMES = 15,
  parameter int BLINK_COUNT  = 4,
  parameter int HOLD_FRAMES  = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       crash,
  input  logic       frame_tick,
  input  logic       restart_btn,
  output logic       crash_en,
  output logic       game_freeze,
  output logic       game_reset,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    BLINK    = 3'd1,
    HOLD     = 3'd2,
    WAIT_BTN = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [3:0] HALF_LAST  = 4'(2 * BLINK_COUNT - 1);

  state_t     state, state_nxt;
  logic [7:0] fcnt, fcnt_nxt;
  logic [3:0] hcnt, hcnt_nxt;
  logic       crash_en_nxt, game_freeze_nxt, game_reset_nxt;
  logic       btn_prev;
  logic       btn_edge;

  // btn_prev resets high so a button held through reset never looks like a press.
  assign btn_edge  = restart_btn & ~btn_prev;
  assign seq_state = state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      fcnt        <= '0;
      hcnt        <= '0;
      crash_en    <= 1'b0;
      game_freeze <= 1'b0;
      game_reset  <= 1'b0;
      btn_prev    <= 1'b1;
    end else begin
      state       <= state_nxt;
      fcnt        <= fcnt_nxt;
      hcnt        <= hcnt_nxt;
      crash_en    <= crash_en_nxt;
      game_freeze <= game_freeze_nxt;
      game_reset  <= game_reset_nxt;
      btn_prev    <= restart_btn;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt       = state;
    fcnt_nxt        = fcnt;
    hcnt_nxt        = hcnt;
    crash_en_nxt    = crash_en;
    game_freeze_nxt = game_freeze;
    game_reset_nxt  = 1'b0;

    case (state)
      RUN: begin
        crash_en_nxt    = 1'b0;
        game_freeze_nxt = 1'b0;
        if (crash) begin
          // A frame_tick in this same cycle is deliberately not counted.
          state_nxt       = BLINK;
          crash_en_nxt    = 1'b1;
          game_freeze_nxt = 1'b1;
          fcnt_nxt        = '0;
          hcnt_nxt        = '0;
        end
      end

      BLINK: begin
        game_freeze_nxt = 1'b1;
        if (frame_tick) begin
          if (fcnt == BLINK_LAST) begin
            crash_en_nxt = ~crash_en;
            fcnt_nxt     = '0;
            hcnt_nxt     = hcnt + 4'd1;
            if (hcnt == HALF_LAST) begin
              state_nxt    = HOLD;
              crash_en_nxt = 1'b1;
            end
          end else begin
            fcnt_nxt = fcnt + 8'd1;
          end
        end
      end

      HOLD: begin
        crash_en_nxt    = 1'b1;
        game_freeze_nxt = 1'b1;
        if (frame_tick) begin
          if (fcnt == HOLD_LAST) begin
            state_nxt = WAIT_BTN;
            fcnt_nxt  = '0;
          end else begin
            fcnt_nxt = fcnt + 8'd1;
          end
        end
      end

      WAIT_BTN: begin
        crash_en_nxt    = 1'b1;
        game_freeze_nxt = 1'b1;
        if (btn_edge) begin
          state_nxt      = RELEASE;
          crash_en_nxt   = 1'b0;
          game_reset_nxt = 1'b1;
        end
      end

      RELEASE: begin
        crash_en_nxt    = 1'b0;
        game_freeze_nxt = 1'b1;
        if (frame_tick) begin
          state_nxt       = RUN;
          game_freeze_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt       = RUN;
        fcnt_nxt        = '0;
        hcnt_nxt        = '0;
        crash_en_nxt    = 1'b0;
        game_freeze_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_crash_sequencer.sv
// Scoreboard bench for crash_sequencer: each driven cycle queues the expected
// {seq_state, crash_en, game_freeze, game_reset}, compared after the clock edge.
module tb_crash_sequencer;

  localparam int BF = 2;
  localparam int BC = 2;
  localparam int HF = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       crash = 1'b0;
  logic       frame_tick = 1'b0;
  logic       restart_btn = 1'b0;
  logic       crash_en, game_freeze, game_reset;
  logic [2:0] seq_state;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   rst_pulses = 0;

  crash_sequencer #(
    .BLINK_FRAMES(BF),
    .BLINK_COUNT (BC),
    .HOLD_FRAMES (HF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .crash      (crash),
    .frame_tick (frame_tick),
    .restart_btn(restart_btn),
    .crash_en   (crash_en),
    .game_freeze(game_freeze),
    .game_reset (game_reset),
    .seq_state  (seq_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [5:0] outs();
    return {seq_state, crash_en, game_freeze, game_reset};
  endfunction

  // Pop every expectation queued for this edge once outputs have settled.
  always @(posedge clk) begin
    #1;
    if (game_reset === 1'b1) rst_pulses++;
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, outs(), e.val);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic c, input logic t, input logic b, input string tag,
                      input logic [5:0] exp);
    @(negedge clk);
    crash       = c;
    frame_tick  = t;
    restart_btn = b;
    sb.push_back('{tag, exp});
  endtask

  // One frame period: 7 quiet cycles then a tick. pre/post are {state, en, freeze}.
  task automatic frame(input logic btn_base, input logic press, input string tag,
                       input logic [4:0] pre, input logic [4:0] post);
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b0, btn_base | (press & (i == 2 || i == 3)), tag, {pre, 1'b0});
    step(1'b0, 1'b1, btn_base, tag, {post, 1'b0});
  endtask

  // From just after BLINK entry (overlay on) through tick last_k.
  task automatic blink_seq(input logic btn_base, input logic press, input int last_k,
                           input string tag);
    logic [7:0] en_tab;
    logic [2:0] st_pre, st_post;
    logic       en_pre, en_post;
    en_tab  = 8'b1001_1001;  // overlay level after blink ticks 1..8
    st_post = 3'd1;
    en_post = 1'b1;
    for (int k = 1; k <= last_k; k++) begin
      st_pre  = st_post;
      en_pre  = en_post;
      st_post = (k < 8) ? 3'd1 : (k < 11) ? 3'd2 : 3'd3;
      en_post = (k <= 8) ? en_tab[k-1] : 1'b1;
      frame(btn_base, press, $sformatf("%s_t%0d", tag, k),
            {st_pre, en_pre, 1'b1}, {st_post, en_post, 1'b1});
    end
  endtask

  // Press from WAIT_BTN, then resume play on the next frame tick.
  task automatic exit_seq(input string tag);
    step(1'b0, 1'b0, 1'b1, {tag, "_press"}, {3'd4, 1'b0, 1'b1, 1'b1});
    step(1'b0, 1'b0, 1'b0, {tag, "_pulse_end"}, {3'd4, 1'b0, 1'b1, 1'b0});
    frame(1'b0, 1'b0, {tag, "_resume"}, {3'd4, 1'b0, 1'b1}, {3'd0, 1'b0, 1'b0});
    step(1'b0, 1'b0, 1'b0, {tag, "_run"}, 6'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset with the button already held high (carried into test 3).
    restart_btn = 1'b1;
    #23;
    check("reset_outs", outs(), 6'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle frames with no crash
    rst_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, "idle", 6'd0);
      step(1'b0, 1'b1, 1'b1, "idle_tick", 6'd0);
    end

    // 2 + 3: crash pulse with button held throughout; no edge, no reset pulse
    step(1'b1, 1'b0, 1'b1, "crash_entry", {3'd1, 1'b1, 1'b1, 1'b0});
    blink_seq(1'b1, 1'b0, 11, "held");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, "held_wait", {3'd3, 1'b1, 1'b1, 1'b0});
    step(1'b0, 1'b0, 1'b0, "btn_release", {3'd3, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    check("no_reset_held", rst_pulses, 0);
    exit_seq("exit1");
    @(negedge clk);
    check("one_reset_pulse", rst_pulses, 1);

    // 4: presses during BLINK and HOLD are discarded
    rst_pulses = 0;
    step(1'b1, 1'b0, 1'b0, "crash2_entry", {3'd1, 1'b1, 1'b1, 1'b0});
    blink_seq(1'b0, 1'b1, 11, "press");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, "press_wait", {3'd3, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    check("no_reset_discard", rst_pulses, 0);
    exit_seq("exit2");

    // 5: crash with coincident frame_tick; that tick is not counted
    step(1'b1, 1'b1, 1'b0, "crash_tick", {3'd1, 1'b1, 1'b1, 1'b0});
    blink_seq(1'b0, 1'b0, 4, "coinc");

    // 6: async reset mid-BLINK while overlay is on
    @(negedge clk);
    crash = 1'b0; frame_tick = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 6'd0);
    @(negedge clk);
    check("reset_held", outs(), 6'd0);
    rst_n = 1'b1;
    rst_pulses = 0;
    step(1'b0, 1'b0, 1'b0, "post_reset", 6'd0);
    step(1'b1, 1'b0, 1'b0, "crash3_entry", {3'd1, 1'b1, 1'b1, 1'b0});
    blink_seq(1'b0, 1'b0, 11, "again");
    exit_seq("exit3");
    @(negedge clk);
    check("one_reset_again", rst_pulses, 1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crash_sequencer.md
Name: crash_sequencer

Overview:
- Game-over sequencer that owns the enable of the crash text overlay ("DIED!") and the freeze/restart handshake with the game core.
- On a collision it blinks the overlay at frame rate, then holds it steady. After a minimum hold time it waits for a fresh restart press, then issues a one-cycle game reset.
- Sits between the collision logic, the frame-tick generator of the VGA sync block, the debounced restart button, and the overlay renderer.

Parameters:
- BLINK_FRAMES, 15, frame ticks per blink half-period; legal range 1..255.
- BLINK_COUNT, 4, number of off/on blink cycles; legal range 1..7.
- HOLD_FRAMES, 120, frame ticks of steady display before a restart is accepted; legal range 1..255.

Ports:
- clk  input  1  system/pixel clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- crash  input  1  collision flag, level or pulse, sampled each clk.
- frame_tick  input  1  one-clk pulse per video frame (start of vsync).
- restart_btn  input  1  debounced restart button level, active high.
- crash_en  output  1  enables the crash overlay.
- game_freeze  output  1  stalls player, obstacle and score updates.
- game_reset  output  1  one-clk pulse that reinitialises game state.
- seq_state  output  3  current state encoding, for debug LEDs.

Behaviour:
- All outputs are registered.
- Reset values: state RUN (seq_state=0), crash_en=0, game_freeze=0, game_reset=0, all counters 0, btn_prev=1.
- btn_prev reset to 1 means a button held through reset produces no edge.
- Restart edge is restart_btn & ~btn_prev, with btn_prev registered every cycle in every state.
- Counters:
  - fcnt, 8 bit: frame ticks counted in the current phase.
  - hcnt, 4 bit: half-periods completed.
- State encodings: RUN=0, BLINK=1, HOLD=2, WAIT_BTN=3, RELEASE=4. Unused encodings go to RUN.
- RUN: crash_en=0, game_freeze=0.
  - crash=1 -> BLINK. crash_en=1 and game_freeze=1 on the next edge (latency 1 clk). fcnt=0, hcnt=0.
  - A frame_tick arriving together with crash is not counted.
- BLINK: game_freeze=1.
  - On frame_tick with fcnt==BLINK_FRAMES-1: toggle crash_en, fcnt=0, hcnt+1. Any other frame_tick: fcnt+1.
  - At the toggle where hcnt==2*BLINK_COUNT-1: -> HOLD with crash_en=1 and fcnt=0. The overlay ends on.
- HOLD: crash_en=1, game_freeze=1.
  - frame_tick increments fcnt. On frame_tick with fcnt==HOLD_FRAMES-1: -> WAIT_BTN.
  - Restart edges in this state are discarded, not queued.
- WAIT_BTN: crash_en=1, game_freeze=1.
  - Restart edge -> RELEASE. game_reset=1 for exactly that one following clk. crash_en=0 on the same edge.
- RELEASE: crash_en=0, game_freeze=1.
  - Next frame_tick -> RUN with game_freeze=0, so play resumes on a frame boundary.
  - If frame_tick coincides with the cycle game_reset is high, the transition still occurs on that tick.
- crash is ignored in every state except RUN. A crash still asserted on the first RUN cycle starts a new sequence.
- frame_tick is ignored in RUN and WAIT_BTN.
- Asynchronous reset in any state returns all outputs to reset values immediately, with no game_reset pulse.
- No combinational path from any input to any output.

Test Plan:
Use BLINK_FRAMES=2, BLINK_COUNT=2, HOLD_FRAMES=3 unless stated otherwise.
1. Reset released; 10 frame_ticks with crash=0 -> seq_state=0, crash_en=0, game_freeze=0, game_reset never 1.
2. 1-clk crash pulse, then frame_ticks every 8 clks -> crash_en=1 one clk after crash; crash_en sequence across ticks 2/4/6/8 = 0,1,0,1; seq_state=2 after tick 8; crash_en stays 1; seq_state=3 after 3 more ticks.
3. restart_btn held high from before reset through the whole sequence into WAIT_BTN -> no game_reset. Release then press -> seq_state=4 and game_reset high exactly 1 clk. Next frame_tick -> seq_state=0, game_freeze=0.
4. Restart pressed and released during BLINK and during HOLD -> no transition and no game_reset; seq_state reaches 3 on schedule.
5. crash and frame_tick asserted in the same clk in RUN -> BLINK entered with fcnt=0; first toggle occurs after 2 further ticks, not 1.
6. rst_n pulsed low mid-BLINK while crash_en=1 -> crash_en, game_freeze, game_reset all 0 within the reset assertion and seq_state=0. A crash after release restarts the full sequence.
